temporal_max_n: RTL and testbench

TEMPORAL_MAX_N -- requirements
Module: temporal_max_n

---
 rtl/temporal_max_n.sv | 155 +++++++++++++++
 tb/tb_temporal_max_n.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/temporal_max_n.sv
// Temporal race-logic resolver: arms on set, timestamps the first spike per channel and
// reports the MAX, tie-excluding MAX, or MIN arrival of the wave as an edge-coded result.
module temporal_max_n #(
    parameter int N    = 4,
    parameter int TW   = 8,
    parameter int MODE = 1,
    parameter int EDGE = 0,
    localparam int IW  = (N > 1) ? $clog2(N) : 1
) (
    input  logic          aclk,
    input  logic          grst,
    input  logic          set,
    input  logic [N-1:0]  in,
    output logic          q,
    output logic [TW-1:0] q_time,
    output logic [IW-1:0] q_idx,
    output logic          valid,
    output logic          tie,
    output logic          timeout,
    output logic          busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [N-1:0]  CH_ONE  = {{(N-1){1'b0}}, 1'b1};
    localparam logic [TW-1:0] CNT_ONE = {{(TW-1){1'b0}}, 1'b1};
    localparam logic [TW-1:0] CNT_MAX = {TW{1'b1}};
    localparam logic [N-1:0]  PREV_RST = (EDGE == 0) ? {N{1'b0}} : {N{1'b1}};

    state_t          r_state;
    logic [N-1:0]    r_prev;
    logic [N-1:0]    r_arrived;
    logic [TW-1:0]   r_count;
    logic            r_q;
    logic [TW-1:0]   r_q_time;
    logic [IW-1:0]   r_q_idx;
    logic            r_valid;
    logic            r_tie;
    logic            r_timeout;

    logic [N-1:0]    w_spike;
    logic [N-1:0]    w_new;
    logic [N-1:0]    w_all;
    logic            w_multi;
    logic            w_tie;
    logic            w_resolve;
    logic            w_expire;
    logic [IW-1:0]   w_low_idx;

    assign w_spike = (EDGE == 0) ? (in & ~r_prev) : (~in & r_prev);
    // Only first spikes of an armed, non-restarting cycle count as arrivals.
    assign w_new   = (set || (r_state != S_ARMED)) ? '0 : (w_spike & ~r_arrived);
    assign w_all   = r_arrived | w_new;
    assign w_multi = |(w_new & (w_new - CH_ONE));
    assign w_tie   = (MODE == 1) && w_multi;

    always_comb begin
        w_low_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_new[i]) begin
                w_low_idx = i[IW-1:0];
            end
        end
    end

    always_comb begin
        w_resolve = 1'b0;
        if (MODE == 2) begin
            w_resolve = |w_new;
        end else begin
            w_resolve = (|w_new) && (&w_all);
        end
    end

    assign w_expire = (r_state == S_ARMED) && !set && (r_count == CNT_MAX);

    always_ff @(posedge aclk or negedge grst) begin
        if (!grst) begin
            r_prev <= PREV_RST;
        end else begin
            r_prev <= in;
        end
    end

    always_ff @(posedge aclk or negedge grst) begin
        if (!grst) begin
            r_state   <= S_IDLE;
            r_arrived <= '0;
            r_count   <= '0;
            r_q       <= 1'b0;
            r_q_time  <= '0;
            r_q_idx   <= '0;
            r_valid   <= 1'b0;
            r_tie     <= 1'b0;
            r_timeout <= 1'b0;
        end else if (set) begin
            r_state   <= S_ARMED;
            r_arrived <= '0;
            r_count   <= '0;
            r_q       <= 1'b0;
            r_valid   <= 1'b0;
            r_tie     <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_state <= S_IDLE;
                end
                S_ARMED: begin
                    r_arrived <= w_all;
                    // Resolution wins over expiry when both land on the last count.
                    if (w_resolve) begin
                        r_state   <= S_DONE;
                        r_valid   <= 1'b1;
                        r_q       <= !w_tie;
                        r_tie     <= w_tie;
                        r_timeout <= 1'b0;
                        r_q_time  <= r_count;
                        r_q_idx   <= w_tie ? '0 : w_low_idx;
                    end else if (w_expire) begin
                        r_state   <= S_DONE;
                        r_valid   <= 1'b1;
                        r_q       <= 1'b0;
                        r_tie     <= 1'b0;
                        r_timeout <= 1'b1;
                        r_q_time  <= CNT_MAX;
                        r_q_idx   <= '0;
                    end else begin
                        r_count <= r_count + CNT_ONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign q       = r_q;
    assign q_time  = r_q_time;
    assign q_idx   = r_q_idx;
    assign valid   = r_valid;
    assign tie     = r_tie;
    assign timeout = r_timeout;
    assign busy    = (r_state == S_ARMED);

endmodule

// File: tb/tb_temporal_max_n.sv
// Bench for temporal_max_n: five configurations share one stimulus bus and each is
// checked against an arrival-time model of its mode.
module tb_temporal_max_n;

    localparam int NDUT  = 5;
    localparam int NEVER = 1000;

    logic       aclk;
    logic       grst;
    logic       set_s;
    logic [3:0] in_lvl;
    logic [1:0] in_inv;

    logic [NDUT-1:0] w_q, w_valid, w_tie, w_to, w_busy;
    logic [7:0]      w_qt [NDUT];
    logic [0:0]      qi0, qi1, qi2;
    logic [1:0]      qi3, qi4;

    int nch  [NDUT] = '{2, 2, 2, 4, 4};
    int mdl  [NDUT] = '{1, 0, 1, 2, 1};

    int n_cmp  = 0;
    int n_fail = 0;

    assign in_inv = ~in_lvl[1:0];

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    temporal_max_n #(.N(2), .TW(8), .MODE(1), .EDGE(0)) u_d0 (
        .aclk(aclk), .grst(grst), .set(set_s), .in(in_lvl[1:0]),
        .q(w_q[0]), .q_time(w_qt[0]), .q_idx(qi0), .valid(w_valid[0]),
        .tie(w_tie[0]), .timeout(w_to[0]), .busy(w_busy[0]));

    temporal_max_n #(.N(2), .TW(8), .MODE(0), .EDGE(0)) u_d1 (
        .aclk(aclk), .grst(grst), .set(set_s), .in(in_lvl[1:0]),
        .q(w_q[1]), .q_time(w_qt[1]), .q_idx(qi1), .valid(w_valid[1]),
        .tie(w_tie[1]), .timeout(w_to[1]), .busy(w_busy[1]));

    temporal_max_n #(.N(2), .TW(8), .MODE(1), .EDGE(1)) u_d2 (
        .aclk(aclk), .grst(grst), .set(set_s), .in(in_inv),
        .q(w_q[2]), .q_time(w_qt[2]), .q_idx(qi2), .valid(w_valid[2]),
        .tie(w_tie[2]), .timeout(w_to[2]), .busy(w_busy[2]));

    temporal_max_n #(.N(4), .TW(8), .MODE(2), .EDGE(0)) u_d3 (
        .aclk(aclk), .grst(grst), .set(set_s), .in(in_lvl),
        .q(w_q[3]), .q_time(w_qt[3]), .q_idx(qi3), .valid(w_valid[3]),
        .tie(w_tie[3]), .timeout(w_to[3]), .busy(w_busy[3]));

    temporal_max_n #(.N(4), .TW(8), .MODE(1), .EDGE(0)) u_d4 (
        .aclk(aclk), .grst(grst), .set(set_s), .in(in_lvl),
        .q(w_q[4]), .q_time(w_qt[4]), .q_idx(qi4), .valid(w_valid[4]),
        .tie(w_tie[4]), .timeout(w_to[4]), .busy(w_busy[4]));

    function automatic logic [31:0] f_idx(input int k);
        case (k)
            0:       return {31'b0, qi0};
            1:       return {31'b0, qi1};
            2:       return {31'b0, qi2};
            3:       return {30'b0, qi3};
            default: return {30'b0, qi4};
        endcase
    endfunction

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s dut%0d observed=%0d expected=%0d", tag, k, obs, exp);
        end
    endtask

    // Expected outcome from the arrival times: the wave ends at the latest (or earliest)
    // first arrival, or at the last count if the channels never all show up.
    task automatic model(input int nc, input int md, input int t[4], output int et,
                         output int eq, output int ei, output int etie, output int eto);
        int best;
        int cnt;
        int idx;
        best = (md == 2) ? NEVER : 0;
        for (int i = 0; i < nc; i++) begin
            if (md == 2 && t[i] < best) best = t[i];
            if (md != 2 && t[i] > best) best = t[i];
        end
        if (best > 255) begin
            et = 255; eq = 0; ei = 0; etie = 0; eto = 1;
        end else begin
            cnt = 0;
            idx = -1;
            for (int i = 0; i < nc; i++) begin
                if (t[i] == best) begin
                    cnt++;
                    if (idx < 0) idx = i;
                end
            end
            et  = best;
            eto = 0;
            if (md == 1 && cnt >= 2) begin
                eq = 0; etie = 1; ei = 0;
            end else begin
                eq = 1; etie = 0; ei = idx;
            end
        end
    endtask

    task automatic chk_zero(input string tag);
        for (int k = 0; k < NDUT; k++) begin
            chk({tag, "_q"}, k, 32'(w_q[k]), 0);
            chk({tag, "_qtime"}, k, 32'(w_qt[k]), 0);
            chk({tag, "_qidx"}, k, f_idx(k), 0);
            chk({tag, "_valid"}, k, 32'(w_valid[k]), 0);
            chk({tag, "_tie"}, k, 32'(w_tie[k]), 0);
            chk({tag, "_timeout"}, k, 32'(w_to[k]), 0);
            chk({tag, "_busy"}, k, 32'(w_busy[k]), 0);
        end
    endtask

    task automatic run_wave(input int t[4], input int maxc);
        int et [NDUT];
        int eq [NDUT];
        int ei [NDUT];
        int etie [NDUT];
        int eto [NDUT];
        int vcnt [NDUT];
        int vcyc [NDUT];
        logic [31:0] oq [NDUT];
        logic [31:0] ot [NDUT];
        logic [31:0] oi [NDUT];
        logic [31:0] otie [NDUT];
        logic [31:0] oto [NDUT];
        for (int k = 0; k < NDUT; k++) begin
            model(nch[k], mdl[k], t, et[k], eq[k], ei[k], etie[k], eto[k]);
            vcnt[k] = 0;
            vcyc[k] = -1;
            oq[k] = '0; ot[k] = '0; oi[k] = '0; otie[k] = '0; oto[k] = '0;
        end
        @(negedge aclk);
        set_s  = 1'b1;
        in_lvl = 4'h0;
        @(negedge aclk);
        set_s = 1'b0;
        for (int c = 0; c < maxc; c++) begin
            for (int k = 0; k < NDUT; k++) begin
                if (c == 0) begin
                    chk("clr_q", k, 32'(w_q[k]), 0);
                    chk("clr_tie", k, 32'(w_tie[k]), 0);
                    chk("clr_timeout", k, 32'(w_to[k]), 0);
                end
                chk("busy", k, 32'(w_busy[k]), (c <= et[k]) ? 1 : 0);
                if (w_valid[k] === 1'b1) begin
                    if (vcnt[k] == 0) begin
                        vcyc[k] = c - 1;
                        oq[k]   = 32'(w_q[k]);
                        ot[k]   = 32'(w_qt[k]);
                        oi[k]   = f_idx(k);
                        otie[k] = 32'(w_tie[k]);
                        oto[k]  = 32'(w_to[k]);
                    end
                    vcnt[k]++;
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (t[i] == c) in_lvl[i] = 1'b1;
            end
            @(negedge aclk);
        end
        for (int k = 0; k < NDUT; k++) begin
            if (et[k] <= maxc - 2) begin
                chk("valid_count", k, vcnt[k], 1);
                chk("valid_cycle", k, vcyc[k], et[k]);
                chk("q", k, oq[k], eq[k]);
                chk("q_time", k, ot[k], et[k]);
                chk("q_idx", k, oi[k], ei[k]);
                chk("tie", k, otie[k], etie[k]);
                chk("timeout", k, oto[k], eto[k]);
                chk("hold_q", k, 32'(w_q[k]), eq[k]);
                chk("hold_q_time", k, 32'(w_qt[k]), et[k]);
            end
        end
    endtask

    initial begin
        int t [4];
        int r;
        grst   = 1'b0;
        set_s  = 1'b0;
        in_lvl = 4'h0;
        repeat (3) @(negedge aclk);
        chk_zero("reset");
        grst = 1'b1;
        repeat (2) @(negedge aclk);
        chk_zero("idle");

        t = '{3, 7, NEVER, NEVER};           run_wave(t, 260);
        t = '{9, 2, NEVER, NEVER};           run_wave(t, 260);
        t = '{5, 5, NEVER, NEVER};           run_wave(t, 260);
        t = '{NEVER, NEVER, NEVER, NEVER};   run_wave(t, 260);
        t = '{255, 10, 255, 255};            run_wave(t, 260);
        t = '{254, 254, 20, 1};              run_wave(t, 260);
        t = '{6, NEVER, 4, NEVER};           run_wave(t, 10);
        t = '{NEVER, 3, NEVER, 8};           run_wave(t, 260);
        t = '{1, 4, 4, 2};                   run_wave(t, 260);

        // Reset in the middle of a wave, then check a held-high level is not a spike.
        @(negedge aclk);
        set_s  = 1'b1;
        in_lvl = 4'h0;
        @(negedge aclk);
        set_s = 1'b0;
        repeat (3) @(negedge aclk);
        grst   = 1'b0;
        in_lvl = 4'hF;
        #1;
        chk_zero("midreset");
        @(negedge aclk);
        grst = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge aclk);
            for (int k = 0; k < NDUT; k++) begin
                chk("post_rst_valid", k, 32'(w_valid[k]), 0);
                chk("post_rst_busy", k, 32'(w_busy[k]), 0);
            end
        end
        set_s = 1'b1;
        @(negedge aclk);
        set_s = 1'b0;
        for (int c = 0; c < 20; c++) begin
            for (int k = 0; k < NDUT; k++) begin
                chk("held_valid", k, 32'(w_valid[k]), 0);
                chk("held_busy", k, 32'(w_busy[k]), 1);
            end
            @(negedge aclk);
        end

        for (int w = 0; w < 24; w++) begin
            for (int i = 0; i < 4; i++) begin
                r = $urandom_range(0, 9);
                if (r == 0)      t[i] = NEVER;
                else if (r == 1) t[i] = 255 - $urandom_range(0, 1);
                else             t[i] = $urandom_range(0, 20);
            end
            if ($urandom_range(0, 3) == 0) t[1] = t[0];
            run_wave(t, 260);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
